fpmul_result_collector: RTL

Downstream consumer of the FP multiplier wrapper's output handshake. Accepts IEEE-754 single-precision results over valid/ready and buffers them in a small FIFO. Classifies each word on entry and keeps saturating per-class counters. Presents the buffered words, each with its class tag, on a drain port for the bench or a downstream sink.

---
 rtl/fpcoll_pkg.sv | 33 +++
 rtl/fpcoll_fifo.sv | 49 ++++
 rtl/fpmul_result_collector.sv | 90 +++++++++
 3 files changed

// File: rtl/fpcoll_pkg.sv
// Shared types and helpers for the FP result collector: class tags, field widths
// and the push-time classifier.
package fpcoll_pkg;

   typedef enum logic [2:0] {
      ZERO = 3'd0,
      SUB  = 3'd1,
      NORM = 3'd2,
      INF  = 3'd3,
      QNAN = 3'd4,
      SNAN = 3'd5
   } fp_class_e;

   localparam int unsigned EXP_W = 8;
   localparam int unsigned MAN_W = 23;
   localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

   // Sign bit is ignored.
   function automatic fp_class_e classify(input logic [31:0] d);
      logic [EXP_W-1:0] e;
      logic [MAN_W-1:0] m;
      e = d[EXP_W+MAN_W-1:MAN_W];
      m = d[MAN_W-1:0];
      if (e == '0) begin
         return (m == '0) ? ZERO : SUB;
      end else if (e == EXP_MAX) begin
         if (m == '0) return INF;
         return m[MAN_W-1] ? QNAN : SNAN;
      end
      return NORM;
   endfunction

endpackage

// File: rtl/fpcoll_fifo.sv
// First-word-fall-through FIFO with extended pointers for full/empty discrimination.
// Flush resets both pointers and overrides any push or pop in the same cycle.
module fpcoll_fifo #(
   parameter int unsigned WIDTH = 35,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_q, rd_ptr_q;
   logic             push_ok, pop_ok;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign level   = wr_ptr_q - rd_ptr_q;
   assign push_ok = push && !full && !flush;
   assign pop_ok  = pop && !empty && !flush;
   assign rdata   = mem[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q[AW-1:0]] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

endmodule

// File: rtl/fpmul_result_collector.sv
// Buffers FP multiplier results, tags each with its class and keeps saturating class counters.
// Optional FPCOLL_TRACE_EN prints every popped word in simulation.
module fpmul_result_collector
   import fpcoll_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [31:0]              in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     flush,
   input  logic                     clr_cnt,
   output logic [31:0]              out_data,
   output logic [2:0]               out_class,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic [CNT_W-1:0]         cnt_zero,
   output logic [CNT_W-1:0]         cnt_sub,
   output logic [CNT_W-1:0]         cnt_norm,
   output logic [CNT_W-1:0]         cnt_inf,
   output logic [CNT_W-1:0]         cnt_nan
);

   logic             rdy_q;
   logic             full, empty, push, pop;
   fp_class_e        in_cls;
   logic [2:0]       cnt_idx;
   logic [34:0]      rdata;
   logic [CNT_W-1:0] cnt_q [5];

   // in_ready is held low until the first edge after reset releases.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rdy_q <= 1'b0;
      else     rdy_q <= 1'b1;
   end

   assign in_ready  = rdy_q && !full && !flush;
   assign push      = in_valid && in_ready;
   assign out_valid = !empty;
   assign pop       = out_valid && out_ready && !flush;
   assign in_cls    = classify(in_data);
   assign cnt_idx   = (in_cls == SNAN) ? 3'd4 : in_cls;
   assign out_data  = empty ? 32'h0 : rdata[31:0];
   assign out_class = empty ? 3'd0  : rdata[34:32];

   fpcoll_fifo #(
      .WIDTH (35),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .wdata ({in_cls, in_data}),
      .rdata (rdata),
      .level (level),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
      end else begin
`ifdef FPCOLL_TRACE_EN
         if (pop) begin
            $display("fpcoll pop %f 0x%08h %s", $bitstoshortreal(out_data), out_data,
                     fp_class_e'(out_class).name());
         end
`endif
         if (clr_cnt) begin
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
         end else if (push && (cnt_q[cnt_idx] != '1)) begin
            cnt_q[cnt_idx] <= cnt_q[cnt_idx] + CNT_W'(1);
         end
      end
   end

   assign cnt_zero = cnt_q[0];
   assign cnt_sub  = cnt_q[1];
   assign cnt_norm = cnt_q[2];
   assign cnt_inf  = cnt_q[3];
   assign cnt_nan  = cnt_q[4];

endmodule
